// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan router: hex glyph table, blank code, width helper.
// Glyph bit order is {g,f,e,d,c,b,a}, active-high.
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Counter width for a modulus n; never narrower than one bit.
    function automatic int fw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg_decoder.sv
// Combinational 4-bit value to seven-segment glyph lookup.
// Zero latency; no flow control.
module seg_decoder
    import seg_pkg::*;
(
    input  logic [3:0] val,
    output logic [6:0] glyph
);

    assign glyph = GLYPH[val];

endmodule

// File: rtl/seg_scan_router.sv
// Time-multiplexed seven-segment router: per-frame input snapshot, XOR/rotate digit permutation, blanked scan.
// seg/digit_en lag the scan counters by one cycle; no backpressure, the scan free-runs.
module seg_scan_router
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DIN_W      = 3,
    parameter int SCAN_DIV   = 1000,
    parameter int BLANK      = 2,
    parameter int ROT_DIV    = 250,
    localparam int FW        = fw_of(NUM_DIGITS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_DIGITS*DIN_W-1:0] din,
    input  logic [FW-1:0]               form,
    input  logic                        rot_en,
    input  logic                        rot_clr,
    output logic [6:0]                  seg,
    output logic [NUM_DIGITS-1:0]       digit_en,
    output logic [FW-1:0]               rot,
    output logic                        frame_start
);

    localparam int PW = fw_of(SCAN_DIV);
    localparam int RW = fw_of(ROT_DIV);

    localparam logic [PW-1:0] PRE_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] BLANK_END = PW'(BLANK);
    localparam logic [FW-1:0] IDX_LAST  = FW'(NUM_DIGITS - 1);
    localparam logic [RW-1:0] FCNT_LAST = RW'(ROT_DIV - 1);

    logic [PW-1:0]               pre;
    logic [FW-1:0]               idx;
    logic [RW-1:0]               fcnt;
    logic                        started;

    logic [NUM_DIGITS*DIN_W-1:0] din_s;
    logic [FW-1:0]               form_s;
    logic                        rot_en_s;

    logic                        pre_wrap;
    logic                        end_of_frame;
    logic                        load;
    logic [FW-1:0]               ch;
    logic [DIN_W-1:0]            chan_val;
    logic [3:0]                  dec_in;
    logic [6:0]                  glyph;
    logic                        blank;

    assign pre_wrap     = (pre == PRE_LAST);
    assign end_of_frame = pre_wrap && (idx == IDX_LAST);
    // The very first edge out of reset also takes a snapshot so frame 0 shows live data.
    assign load         = !started || end_of_frame;

    // Position idx is mirrored, XOR-permuted by form, then shifted by the rotate offset.
    assign ch       = ((IDX_LAST - idx) ^ form_s) + rot;
    assign chan_val = din_s[ch*DIN_W +: DIN_W];
    assign dec_in   = 4'(chan_val);
    assign blank    = (pre < BLANK_END);

    seg_decoder u_dec (
        .val   (dec_in),
        .glyph (glyph)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre      <= '0;
            idx      <= '0;
            fcnt     <= '0;
            rot      <= '0;
            started  <= 1'b0;
            din_s    <= '0;
            form_s   <= '0;
            rot_en_s <= 1'b0;
        end else begin
            started <= 1'b1;

            if (pre_wrap) begin
                pre <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                pre <= pre + 1'b1;
            end

            if (load) begin
                din_s    <= din;
                form_s   <= form;
                rot_en_s <= rot_en;
            end

            // Clear beats a coincident rotate step.
            if (rot_clr) begin
                rot  <= '0;
                fcnt <= '0;
            end else if (end_of_frame && rot_en_s) begin
                if (fcnt == FCNT_LAST) begin
                    fcnt <= '0;
                    rot  <= rot + 1'b1;
                end else begin
                    fcnt <= fcnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg         <= SEG_BLANK;
            digit_en    <= '0;
            frame_start <= 1'b0;
        end else begin
            seg         <= blank ? SEG_BLANK : glyph;
            digit_en    <= NUM_DIGITS'(1) << idx;
            frame_start <= load;
        end
    end

endmodule

// File: tb/tb_seg_scan_router.sv
// Bench for seg_scan_router: vector table, hand-written corner sequences, randomized run vs frame-level model.
module tb_seg_scan_router;

    localparam int ND = 4;
    localparam int DW = 3;
    localparam int SD = 4;
    localparam int BL = 1;
    localparam int RD = 2;
    localparam int FW = 2;
    localparam int FRAME = ND * SD;

    localparam logic [6:0] GREF [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [ND*DW-1:0]  din = '0;
    logic [FW-1:0]     form = '0;
    logic              rot_en = 1'b0;
    logic              rot_clr = 1'b0;
    logic [6:0]        seg;
    logic [ND-1:0]     digit_en;
    logic [FW-1:0]     rot;
    logic              frame_start;

    seg_scan_router #(
        .NUM_DIGITS (ND),
        .DIN_W      (DW),
        .SCAN_DIV   (SD),
        .BLANK      (BL),
        .ROT_DIV    (RD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .form        (form),
        .rot_en      (rot_en),
        .rot_clr     (rot_clr),
        .seg         (seg),
        .digit_en    (digit_en),
        .rot         (rot),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: edges since release, frame snapshot, rotate bookkeeping.
    int               n_edge;
    int               m_rot;
    int               m_fc;
    int               m_form;
    bit               m_roten;
    logic [ND*DW-1:0] m_din;
    logic [6:0]       obs [ND];

    typedef struct packed {
        logic [ND*DW-1:0] din;
        logic [FW-1:0]    form;
        logic [3:0][6:0]  exp;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        n_edge  = 0;
        m_rot   = 0;
        m_fc    = 0;
        m_form  = 0;
        m_roten = 0;
        m_din   = '0;
    endtask

    // One clock edge: predict what the edge produces from the cycle index, then compare.
    task automatic step();
        int c, p, ph, ch, val;
        bit eof, load;
        logic [6:0] es;
        logic [ND*DW-1:0] sh;
        @(posedge clk);
        n_edge++;
        c   = n_edge - 1;
        p   = (c / SD) % ND;
        ph  = c % SD;
        ch  = (((ND - 1 - p) ^ m_form) + m_rot) % ND;
        sh  = m_din >> (ch * DW);
        val = int'(sh[DW-1:0]);
        es  = (ph < BL) ? 7'h00 : GREF[val];
        eof  = (c % FRAME) == FRAME - 1;
        load = (n_edge == 1) || eof;
        if (rot_clr) begin
            m_rot = 0;
            m_fc  = 0;
        end else if (eof && m_roten) begin
            m_fc++;
            if (m_fc == RD) begin
                m_fc  = 0;
                m_rot = (m_rot + 1) % ND;
            end
        end
        if (load) begin
            m_din   = din;
            m_form  = int'(form);
            m_roten = rot_en;
        end
        #1;
        check("seg", 32'(seg), 32'(es));
        check("digit_en", 32'(digit_en), 32'(1) << p);
        check("frame_start", 32'(frame_start), 32'(load));
        check("rot", 32'(rot), 32'(m_rot));
        if (ph == SD - 1) obs[p] = seg;
    endtask

    task automatic do_reset(input logic [ND*DW-1:0] d, input logic [FW-1:0] f, input logic re);
        rst_n   = 1'b0;
        rot_clr = 1'b0;
        din     = d;
        form    = f;
        rot_en  = re;
        repeat (2) @(posedge clk);
        #1;
        check("rst_seg", 32'(seg), 32'h0);
        check("rst_digit_en", 32'(digit_en), 32'h0);
        check("rst_frame_start", 32'(frame_start), 32'h0);
        check("rst_rot", 32'(rot), 32'h0);
        model_reset();
        rst_n = 1'b1;
    endtask

    initial begin
        vecs[0] = '{din: 12'o3210, form: 2'd0, exp: {7'h3F, 7'h06, 7'h5B, 7'h4F}};
        vecs[1] = '{din: 12'o3210, form: 2'd3, exp: {7'h4F, 7'h5B, 7'h06, 7'h3F}};
        vecs[2] = '{din: 12'o7546, form: 2'd1, exp: {7'h66, 7'h7D, 7'h07, 7'h6D}};
        vecs[3] = '{din: 12'o1062, form: 2'd2, exp: {7'h3F, 7'h06, 7'h5B, 7'h7D}};
        model_reset();

        for (int v = 0; v < 4; v++) begin
            do_reset(vecs[v].din, vecs[v].form, 1'b0);
            repeat (FRAME) step();
            for (int p = 0; p < ND; p++)
                check("vec_pos", 32'(obs[p]), 32'(vecs[v].exp[p]));
        end

        // din changes while position 2 is lit; frame 0 must keep the old snapshot.
        do_reset(12'o3210, 2'd0, 1'b0);
        repeat (2 * SD + 1) step();
        din[9 +: 3] = 3'd7;
        repeat (FRAME - 2 * SD - 1) step();
        check("midframe_old", 32'(obs[0]), 32'h4F);
        repeat (FRAME) step();
        check("midframe_new", 32'(obs[0]), 32'h07);

        // Auto-rotate: one step every two frames.
        do_reset(12'o3210, 2'd0, 1'b1);
        for (int f = 1; f <= 8; f++) begin
            repeat (FRAME) step();
            if (f == 3) check("rot1_pos0", 32'(obs[0]), 32'h3F);
            if (f % 2 == 0) check("rot_seq", 32'(rot), 32'((f / 2) % ND));
        end

        // rot_clr on the edge that would step the offset, then fcnt must restart.
        repeat (FRAME) step();
        repeat (FRAME - 1) step();
        rot_clr = 1'b1;
        step();
        rot_clr = 1'b0;
        check("clr_rot", 32'(rot), 32'h0);
        repeat (FRAME) step();
        check("clr_fcnt", 32'(rot), 32'h0);
        repeat (FRAME) step();
        check("clr_restep", 32'(rot), 32'h1);

        // Asynchronous reset in the middle of a digit period.
        repeat (2) step();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_seg", 32'(seg), 32'h0);
        check("async_digit_en", 32'(digit_en), 32'h0);
        check("async_frame_start", 32'(frame_start), 32'h0);
        check("async_rot", 32'(rot), 32'h0);
        @(posedge clk);
        #1;

        for (int it = 0; it < 3; it++) begin
            do_reset(ND*DW'($urandom), FW'($urandom), 1'($urandom));
            for (int cyc = 0; cyc < 400; cyc++) begin
                step();
                if ($urandom_range(0, 9) == 0) din = ND*DW'($urandom);
                if ($urandom_range(0, 19) == 0) form = FW'($urandom);
                if ($urandom_range(0, 29) == 0) rot_en = 1'($urandom);
                rot_clr = ($urandom_range(0, 59) == 0);
            end
            rot_clr = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_router.md
# seg_scan_router

Parametrised, time-multiplexed seven-segment display router for the lab display boards. It takes NUM_DIGITS packed input channels of DIN_W bits each and routes them onto digit positions through an XOR-permutation form plus an optional auto-rotating offset. It drives one shared segment bus and a one-hot digit-enable bus, scanning the digits with ghost-suppression blanking. Inputs are snapshotted once per frame, so each displayed frame is internally consistent.

## Interface
Parameters:
- NUM_DIGITS, 4: channel and digit count; must be a power of two, range 2..16.
- DIN_W, 3: bits per channel; range 1..4. Values are displayed as hex glyphs.
- SCAN_DIV, 1000: clock cycles per digit period; must be at least BLANK+1.
- BLANK, 2: cycles at the start of each digit period during which seg is forced to 0.
- ROT_DIV, 250: frames per auto-rotate step; must be at least 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- din  in  NUM_DIGITS*DIN_W  packed channels; channel c is din[c*DIN_W +: DIN_W].
- form  in  FW=$clog2(NUM_DIGITS)  permutation select.
- rot_en  in  1  enables auto-rotate stepping.
- rot_clr  in  1  synchronous clear of the rotate offset.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-high, registered.
- digit_en  out  NUM_DIGITS  one-hot position enable, active-high, registered.
- rot  out  FW  current rotate offset.
- frame_start  out  1  one-cycle pulse on the edge where shadow registers load.

## Operation
- Counters:
  - pre counts 0..SCAN_DIV-1.
  - idx, the active position, advances when pre wraps and wraps from NUM_DIGITS-1 to 0.
  - fcnt counts frames 0..ROT_DIV-1.
- End of frame is pre==SCAN_DIV-1 and idx==NUM_DIGITS-1.
- Shadow registers load din, form and rot_en on the first clock edge after reset release and at every end of frame; frame_start pulses on those edges. din/form changes mid-frame are not visible until the next frame.
- Channel for position p: ch = (((NUM_DIGITS-1-p) ^ form_s) + rot) mod NUM_DIGITS. form_s is the shadowed form; the arithmetic is FW-bit with natural wrap.
- Rotation:
  - At end of frame with rot_en_s=1, fcnt increments.
  - When fcnt wraps from ROT_DIV-1, rot increments mod NUM_DIGITS.
  - With rot_en_s=0, fcnt and rot hold.
  - rot_clr=1 zeroes rot and fcnt on that edge and wins over a simultaneous step.
- Decode uses a hex glyph table. Examples: 0→7'h3F, 1→7'h06, 2→7'h5B, 3→7'h4F, 4→7'h66, 5→7'h6D, 6→7'h7D, 7→7'h07, A→7'h77, F→7'h71. Narrower DIN_W is zero-extended.
- Blanking: seg=0 while pre<BLANK. digit_en stays asserted during blanking.

## Timing
- Reset values:
  - All counters are 0, shadows are 0, rot=0.
  - Outputs during reset: seg=0, digit_en=0, frame_start=0.
- Output latency: seg and digit_en are registered one cycle behind (idx, pre). On the first edge after release, digit_en=1<<0, seg=0 (blank) and frame_start=1.
- A digit period is exactly SCAN_DIV cycles and a frame is NUM_DIGITS*SCAN_DIV cycles. digit_en changes only at period boundaries and is never zero or multi-hot out of reset.
- Reset mid-frame returns all state to the reset values immediately. No partial frame is resumed.

## Structure
- Shared package seg_pkg holds:
  - the 16-entry glyph constant array;
  - the SEG_BLANK constant;
  - a localparam helper for FW.
- Sub-module seg_decoder (4-bit value → 7-bit glyph, combinational) is instantiated once on the shared path, not per digit.
- The top level holds the counters, shadow registers, permutation adder and output registers.

## Test plan
All scenarios use NUM_DIGITS=4, DIN_W=3, SCAN_DIV=4, BLANK=1, ROT_DIV=2.
- Reset/startup: hold rst_n low, then release → seg=0 and digit_en=0 in reset; on the first edge digit_en=4'b0001 and frame_start=1; digit_en steps 0001→0010→0100→1000 every 4 cycles.
- Form 0: din channels {c3..c0}={3,2,1,0}, form=0 → pos0..3 show 7'h4F, 7'h5B, 7'h06, 7'h3F; seg=0 in the first cycle of each period.
- Form 3: same din, form=3 → pos0..3 show 0, 1, 2, 3 (7'h3F, 7'h06, 7'h5B, 7'h4F).
- Mid-frame change: change din c3 to 7 during pos2 → pos0 still shows 3 this frame and shows 7'h07 from the next frame_start.
- Rotate: rot_en=1 → rot increments after every 2 frames, 0→1→2→3→0. With form=0, rot=1, pos0 shows channel 0 (7'h3F).
- rot_clr: assert rot_clr on the same edge as a rotate step → rot=0, fcnt=0. Then assert rst_n low mid-period → all outputs are 0 asynchronously.
